// File: rtl/excess3_pkg.sv
// rtl/excess3_pkg.sv - shared types and constants for the Excess-3 to BCD serial converter
package excess3_pkg;

  // Frame position and pending borrow are both carried in the state.
  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1_B0 = 3'd1,
    S1_B1 = 3'd2,
    S2_B0 = 3'd3,
    S2_B1 = 3'd4,
    S3_B0 = 3'd5,
    S3_B1 = 3'd6
  } state_e;

  localparam logic [3:0] EXCESS3_BIAS = 4'b0011;
  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam int         FRAME_BITS   = 4;

  // Bit position within the frame that a state processes.
  function automatic logic [1:0] state_bit_idx(input state_e s);
    case (s)
      S1_B0, S1_B1: state_bit_idx = 2'd1;
      S2_B0, S2_B1: state_bit_idx = 2'd2;
      S3_B0, S3_B1: state_bit_idx = 2'd3;
      default:      state_bit_idx = 2'd0;
    endcase
  endfunction

  // Borrow pending into the bit processed by a state.
  function automatic logic state_borrow(input state_e s);
    state_borrow = (s == S1_B1) || (s == S2_B1) || (s == S3_B1);
  endfunction

endpackage

// File: rtl/excess3_to_bcd_serial.sv
// rtl/excess3_to_bcd_serial.sv - bit-serial Excess-3 to BCD converter (Mealy subtract-3 FSM)
module excess3_to_bcd_serial
  import excess3_pkg::*;
#(
  parameter bit CLEAR_ON_ERR = 1'b0
) (
  input  logic       clk100Mhz,
  input  logic       rst_n,
  input  logic       bit_en,
  input  logic       x_in,
  input  logic       sync,
  output logic       z_out,
  output logic [3:0] bcd_digit,
  output logic       digit_valid,
  output logic       code_err
);

  state_e     state_q, state_d;
  logic       z_q, z_d;
  logic [3:0] res_q, res_d;
  logic [3:0] bcd_q, bcd_d;
  logic       dv_q, dv_d;
  logic       err_q, err_d;

  state_e     cur;
  logic [1:0] idx;
  logic       b_in;
  logic       bias_bit;
  logic       bit_z;
  logic       b_out;
  logic [3:0] full;
  logic       frame_err;

  // Per-bit subtraction of the bias; sync forces the current bit to be bit0.
  always_comb begin
    state_d   = state_q;
    z_d       = z_q;
    res_d     = res_q;
    bcd_d     = bcd_q;
    dv_d      = 1'b0;
    err_d     = 1'b0;
    cur       = sync ? S0 : state_q;
    idx       = state_bit_idx(cur);
    b_in      = state_borrow(cur);
    bias_bit  = EXCESS3_BIAS[idx];
    bit_z     = x_in ^ bias_bit ^ b_in;
    b_out     = bias_bit ? (~x_in | b_in) : (~x_in & b_in);
    full      = {bit_z, res_q[3:1]};
    frame_err = 1'b0;
    if (bit_en) begin
      z_d = bit_z;
      case (cur)
        S0:           state_d = b_out ? S1_B1 : S1_B0;
        S1_B0, S1_B1: state_d = b_out ? S2_B1 : S2_B0;
        S2_B0, S2_B1: state_d = b_out ? S3_B1 : S3_B0;
        default:      state_d = S0;
      endcase
      // Starting a frame drops whatever partial result was collected.
      res_d = (cur == S0) ? {bit_z, 3'b000} : full;
      if (cur == S3_B0 || cur == S3_B1) begin
        frame_err = b_out || (full > BCD_MAX);
        bcd_d     = (CLEAR_ON_ERR && frame_err) ? 4'b0000 : full;
        dv_d      = 1'b1;
        err_d     = frame_err;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
      z_q     <= 1'b0;
      res_q   <= 4'b0000;
      bcd_q   <= 4'b0000;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      res_q   <= res_d;
      bcd_q   <= bcd_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  assign z_out       = z_q;
  assign bcd_digit   = bcd_q;
  assign digit_valid = dv_q;
  assign code_err    = err_q;

endmodule

// File: doc/excess3_to_bcd_serial.md
EXCESS3_TO_BCD_SERIAL -- requirements
Module: excess3_to_bcd_serial

Interface
REQ-001 SHALL have parameter: CLEAR_ON_ERR, default 0, when 1 forces bcd_digit to 4'b0000 on any frame flagged code_err.
REQ-002 SHALL have port: clk100Mhz  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: bit_en  input  1  one-cycle strobe; each high cycle consumes exactly one serial bit.
REQ-005 SHALL have port: x_in  input  1  serial Excess-3 data, LSB first, 4 bits per frame.
REQ-006 SHALL have port: sync  input  1  frame-start marker, sampled only when bit_en=1.
REQ-007 SHALL have port: z_out  output  1  serial BCD bit, LSB first.
REQ-008 SHALL have port: bcd_digit  output  4  last completed BCD digit, parallel form.
REQ-009 SHALL have port: digit_valid  output  1  one-cycle pulse when bcd_digit updates.
REQ-010 SHALL have port: code_err  output  1  one-cycle pulse, coincident with digit_valid, when the frame was not a legal Excess-3 code (value <3 or >12).

Function
REQ-011 SHALL implement bit-serial subtraction x - 4'b0011 with borrow, as a Mealy FSM.
- 7 states: S0 (bit0), S1_B0, S1_B1, S2_B0, S2_B1, S3_B0, S3_B1; suffix = pending borrow.
REQ-012 SHALL use the per-bit rules, applied only on cycles with bit_en=1:
- S0: z=~x; next S1_B1 if x=0 else S1_B0.
- S1_Bb: z=x^1^b; borrow'=~x|b.
- S2_Bb / S3_Bb: z=x^b; borrow'=~x&b.
- S3_*: next S0 (wrap).
REQ-013 SHALL register z_out on the bit_en cycle: z_out valid from the following cycle, held until the next bit_en.
REQ-014 SHALL hold state, z_out and the shift register unchanged while bit_en=0; gaps of any length are legal.
REQ-015 SHALL shift each computed z bit into a 4-bit result register, LSB first.
REQ-016 SHALL, on the bit_en cycle in state S3_*, load bcd_digit with the full 4-bit result and pulse digit_valid the next cycle.
REQ-017 SHALL flag code_err when the final borrow out of bit3 is 1 (input <3) or the result is >4'd9 (input >12).
REQ-018 SHALL, when CLEAR_ON_ERR=1 and code_err is flagged, load bcd_digit with 4'b0000; otherwise load the raw difference.
REQ-019 SHALL, on bit_en=1 with sync=1 in any state, discard the partial frame and treat x_in as bit0 (S0 rules); no digit_valid for the discarded frame.
REQ-020 SHALL honour sync=1 in S0: normal bit0 processing with no side effect.
REQ-021 SHALL never pulse digit_valid or code_err for more than one cycle per frame, and never without a preceding S3 bit_en.

Reset
REQ-022 SHALL, on rst_n=0 asynchronously: state=S0, result register=0, z_out=0, bcd_digit=4'b0000, digit_valid=0, code_err=0.
REQ-023 SHALL, on reset mid-frame, drop the partial frame; the first bit_en after release is bit0.
REQ-024 SHALL ignore bit_en during reset.

Structure
REQ-025 SHALL place in shared package excess3_pkg: the FSM state enum, constant EXCESS3_BIAS=4'b0011, constant BCD_MAX=4'd9, constant FRAME_BITS=4.
REQ-026 SHALL be a single module with no sub-module; bit_en is generated externally from a tick derived from clk100Mhz, and no derived clock enters this block.

Verification
REQ-027 SHALL cover frame 1000 (bits 0,0,0,1) -> z_out sequence 1,0,1,0; bcd_digit=4'b0101, digit_valid pulse, code_err=0.
REQ-028 SHALL cover all 16 input codes back-to-back -> 3..12 give bcd 0..9 with code_err=0; 0,1,2,13,14,15 give code_err=1, and bcd_digit=0 when CLEAR_ON_ERR=1.
REQ-029 SHALL cover 1100 sent with 0-7 idle cycles between bit_en strobes -> bcd_digit=4'b1001, z_out stable during gaps.
REQ-030 SHALL cover sync=1 on the 3rd bit of a frame, followed by frame 0011 -> no pulse for the aborted frame; bcd_digit=4'b0000, one digit_valid.
REQ-031 SHALL cover rst_n low after 2 bits of a frame -> all outputs 0 immediately; next frame 0111 -> bcd_digit=4'b0100.
